rr_arbiter4: RTL and testbench
==============================

RR_ARBITER4 -- requirements
Module: rr_arbiter4

Interface
REQ-001 Parameter: MAX_HOLD, default 8, maximum consecutive grant cycles for one owner while other requests are pending; legal range 2..15.
REQ-002 Port: clk  input  1  rising-edge system clock.
REQ-003 Port: rst_n  input  1  asynchronous active-low reset.
REQ-004 Port: req  input  4  request vector; bit i = requester i wants the shared resource.
REQ-005 Port: grant  output  4  registered one-hot grant vector; all-zero = no owner.
REQ-006 Port: grant_id  output  2  index of the current owner; 0 when grant is all-zero.
REQ-007 Port: idle  output  1  high when grant == 4'b0000.
REQ-008 Port: valid  output  1  high when grant has exactly one bit set.
REQ-009 Port: switch  output  1  one-cycle pulse on the cycle grant first shows a new owner.
REQ-010 The block SHALL use one clock; reset is asynchronous and active-low.

Function
REQ-011 The block SHALL implement two states: IDLE (no owner) and OWNED (one owner).
REQ-012 The block SHALL register all outputs; grant SHALL change only on rising clk edges.
REQ-013 Round-robin pointer ptr (2 bits) SHALL define search order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
REQ-014 IDLE: if req != 0 at an edge, grant SHALL become the one-hot of the first set req bit in search order, with latency 1 cycle; state goes to OWNED.
REQ-015 IDLE with req == 0: grant SHALL stay 0 and state SHALL stay IDLE.
REQ-016 On every new grant to index i, ptr SHALL become (i+1) mod 4 at the same edge.
REQ-017 OWNED, req[owner] == 0 at an edge: if any other req bit is set, grant SHALL hand off directly to the next requester in search order with no idle cycle; otherwise grant SHALL go to 0 and state to IDLE.
REQ-018 OWNED, req[owner] == 1: hold counter hcnt (4 bits) SHALL increment each cycle, starting at 0 on the grant edge.
REQ-019 When hcnt == MAX_HOLD-1 and another req bit is set, the next edge SHALL force rotation to the next requester in search order; hcnt SHALL reset to 0.
REQ-020 When hcnt == MAX_HOLD-1 and no other req bit is set, the owner SHALL keep the grant and hcnt SHALL saturate at MAX_HOLD-1; rotation occurs on the first edge at which another request appears.
REQ-021 Re-grant to the same index (A drops, A is the sole requester again in a later cycle) SHALL still pass through IDLE for at least one cycle.
REQ-022 switch SHALL be 1 for exactly one cycle on every edge where grant changes to a different nonzero value; it SHALL be 0 on release to IDLE.
REQ-023 valid SHALL equal (grant is one-hot); idle SHALL equal (grant == 0); valid and idle SHALL never both be 1 and SHALL never both be 0.
REQ-024 Simultaneous release by the owner and a new request from another bit SHALL produce a direct handoff per REQ-017.
REQ-025 X or undefined req bits are not supported; behaviour is defined only for 0/1 inputs.

Reset
REQ-026 While rst_n == 0: grant = 4'b0000, grant_id = 0, idle = 1, valid = 0, switch = 0, ptr = 0, hcnt = 0, state = IDLE, asynchronously.
REQ-027 Reset assertion mid-ownership SHALL clear grant immediately, without waiting for clk.
REQ-028 After rst_n rises, the first grant SHALL follow REQ-014 with ptr = 0.

Verification
REQ-029 Reset, then req=4'b1111 -> one cycle later grant=0001, grant_id=0, switch=1; with req held, rotation every 8 cycles: 0010, 0100, 1000, 0001.
REQ-030 req=0100 only, held 20 cycles -> grant=0100 throughout, no switch pulse after the first, idle=0, valid=1.
REQ-031 Owner 0001 drops req while req=1010 -> next edge grant=0010 (ptr was 1), switch=1, no idle cycle.
REQ-032 Owner drops, req=0000 -> next edge grant=0000, idle=1, valid=0, switch=0.
REQ-033 rst_n pulsed low mid-grant (grant=1000) -> grant=0000 and idle=1 before the next clk edge; after release, req=1001 -> grant=0001.
REQ-034 Every cycle of every scenario -> valid XOR idle = 1 and grant_id matches the set bit of grant.

Source files
------------

// File: rtl/rr_arbiter4.sv
// rr_arbiter4 -- four-way round-robin arbiter with a bounded hold time.
//
// An owner keeps the shared resource while it requests it, but once it has
// held it for MAX_HOLD cycles and someone else is waiting, ownership rotates
// to the next requester in round-robin order. Every output is registered.
//
// Ports
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   req[3:0]  request vector, bit i = requester i wants the resource
//   grant     registered one-hot grant, all-zero when nobody owns it
//   grant_id  index of the current owner, 0 when idle
//   idle      high when grant is all-zero
//   valid     high when grant has exactly one bit set
//   switch    one-cycle pulse on the first cycle a new owner is shown
module rr_arbiter4 #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] grant_id,
  output logic       idle,
  output logic       valid,
  output logic       switch
);

  typedef enum logic {IDLE, OWNED} state_t;

  localparam logic [3:0] HOLD_LIMIT = 4'(MAX_HOLD - 1);

  state_t     state, stateNext;
  logic [1:0] ptr, ptrNext;
  logic [3:0] hcnt, hcntNext;
  logic [3:0] grantNext;
  logic [1:0] idNext;
  logic       switchNext;

  // Candidates for a new grant: in OWNED the current owner is excluded, so a
  // handoff or a forced rotation always lands on a different requester.
  logic [3:0] cand;
  logic       others;
  logic       pickFound;
  logic [1:0] pickIdx;
  logic [1:0] scanIdx;

  always_comb begin
    cand = (state == OWNED) ? (req & ~grant) : req;
    others = |(req & ~grant);
    pickFound = 1'b0;
    pickIdx = 2'd0;
    scanIdx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      scanIdx = ptr + 2'(k);
      if (!pickFound && cand[scanIdx]) begin
        pickFound = 1'b1;
        pickIdx = scanIdx;
      end
    end
  end

  always_comb begin
    stateNext = state;
    ptrNext = ptr;
    hcntNext = hcnt;
    grantNext = grant;
    idNext = grant_id;
    switchNext = 1'b0;
    unique case (state)
      IDLE: begin
        if (pickFound) begin
          stateNext = OWNED;
          grantNext = 4'b0001 << pickIdx;
          idNext = pickIdx;
          ptrNext = pickIdx + 2'd1;
          hcntNext = 4'd0;
          switchNext = 1'b1;
        end
      end
      OWNED: begin
        if (!req[grant_id]) begin
          // Owner released; hand off directly if anyone else is waiting.
          if (others) begin
            grantNext = 4'b0001 << pickIdx;
            idNext = pickIdx;
            ptrNext = pickIdx + 2'd1;
            hcntNext = 4'd0;
            switchNext = 1'b1;
          end else begin
            stateNext = IDLE;
            grantNext = 4'd0;
            idNext = 2'd0;
            hcntNext = 4'd0;
          end
        end else if (hcnt == HOLD_LIMIT) begin
          // Hold budget exhausted: rotate if contended, otherwise saturate.
          if (others) begin
            grantNext = 4'b0001 << pickIdx;
            idNext = pickIdx;
            ptrNext = pickIdx + 2'd1;
            hcntNext = 4'd0;
            switchNext = 1'b1;
          end
        end else begin
          hcntNext = hcnt + 4'd1;
        end
      end
      default: begin
        stateNext = IDLE;
        grantNext = 4'd0;
        idNext = 2'd0;
      end
    endcase
  end

  // All state and outputs are registered; idle/valid derive from grantNext so
  // they always describe the grant shown in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      ptr <= 2'd0;
      hcnt <= 4'd0;
      grant <= 4'd0;
      grant_id <= 2'd0;
      idle <= 1'b1;
      valid <= 1'b0;
      switch <= 1'b0;
    end else begin
      state <= stateNext;
      ptr <= ptrNext;
      hcnt <= hcntNext;
      grant <= grantNext;
      grant_id <= idNext;
      idle <= (grantNext == 4'd0);
      valid <= (grantNext != 4'd0);
      switch <= switchNext;
    end
  end

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb_rr_arbiter4 -- randomized and directed checks of rr_arbiter4 against a
// behavioural model that tracks owner, pointer and cycles held as integers.
module tb_rr_arbiter4;

  localparam int MAX_HOLD = 8;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       idle;
  logic       valid;
  logic       switch;

  int checkCount = 0;
  int passCount = 0;

  // Reference model state: owner index (-1 = none), next search start and
  // number of cycles the owner has been shown on grant.
  int mOwner;
  int mPtr;
  int mHeld;
  bit mSwitch;

  rr_arbiter4 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .grant(grant),
    .grant_id(grant_id),
    .idle(idle),
    .valid(valid),
    .switch(switch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value and log a mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
  endtask

  function automatic int choose(input logic [3:0] cand);
    for (int k = 0; k < 4; k++)
      if (cand[(mPtr + k) % 4]) return (mPtr + k) % 4;
    return -1;
  endfunction

  task automatic grantTo(input int i);
    mOwner = i;
    mPtr = (i + 1) % 4;
    mHeld = 1;
    mSwitch = 1'b1;
  endtask

  // Advance the model by one rising edge that sampled request vector r.
  task automatic modelStep(input logic [3:0] r);
    logic [3:0] oth;
    mSwitch = 1'b0;
    if (mOwner < 0) begin
      if (r != 4'd0) grantTo(choose(r));
    end else begin
      oth = r;
      oth[mOwner] = 1'b0;
      if (!r[mOwner]) begin
        if (oth != 4'd0) grantTo(choose(oth));
        else mOwner = -1;
      end else if (mHeld >= MAX_HOLD && oth != 4'd0) begin
        grantTo(choose(oth));
      end else begin
        mHeld++;
      end
    end
  endtask

  task automatic compareAll();
    logic [3:0] expGrant;
    expGrant = (mOwner < 0) ? 4'd0 : (4'b0001 << mOwner);
    checkOutput("grant", 32'(grant), 32'(expGrant));
    checkOutput("grant_id", 32'(grant_id), (mOwner < 0) ? 32'd0 : 32'(mOwner));
    checkOutput("switch", 32'(switch), 32'(mSwitch));
    checkOutput("idle", 32'(idle), 32'(mOwner < 0));
    checkOutput("validXorIdle", 32'(valid ^ idle), 32'd1);
  endtask

  // Drive r for n cycles starting from a falling edge, checking each cycle.
  task automatic applyStimulus(input logic [3:0] r, input int n);
    for (int c = 0; c < n; c++) begin
      req = r;
      @(posedge clk);
      modelStep(r);
      @(negedge clk);
      compareAll();
    end
  endtask

  // Assert reset away from any clock edge and check it acts immediately.
  task automatic pulseReset();
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rstGrant", 32'(grant), 32'd0);
    checkOutput("rstIdle", 32'(idle), 32'd1);
    checkOutput("rstValid", 32'(valid), 32'd0);
    checkOutput("rstSwitch", 32'(switch), 32'd0);
    checkOutput("rstId", 32'(grant_id), 32'd0);
    mOwner = -1;
    mPtr = 0;
    mHeld = 0;
    mSwitch = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [3:0] curReq;
    req = 4'd0;
    rst_n = 1'b1;
    @(negedge clk);
    pulseReset();

    // Full contention: rotation every MAX_HOLD cycles.
    applyStimulus(4'b1111, 4 * MAX_HOLD + 3);
    applyStimulus(4'b0000, 2);

    pulseReset();
    applyStimulus(4'b0100, 20);

    // Owner 0 drops while 1 and 3 wait: direct handoff to 1.
    applyStimulus(4'b0000, 1);
    pulseReset();
    applyStimulus(4'b0001, 3);
    applyStimulus(4'b1010, 3);
    checkOutput("handoffDirect", 32'(grant), 32'b0010);
    applyStimulus(4'b0000, 2);
    checkOutput("releaseIdle", 32'(idle), 32'd1);

    // Same requester again goes through idle; then reset mid-grant on 3.
    applyStimulus(4'b0010, 2);
    applyStimulus(4'b0000, 1);
    applyStimulus(4'b0010, 2);
    applyStimulus(4'b1000, 3);
    checkOutput("preResetOwner", 32'(grant), 32'b1000);
    pulseReset();
    applyStimulus(4'b1001, 2);
    checkOutput("postResetGrant", 32'(grant), 32'b0001);

    // Random phase with sticky requests so hold limits are exercised.
    curReq = 4'($urandom_range(0, 15));
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 9) < 3) curReq = 4'($urandom_range(0, 15));
      applyStimulus(curReq, 1);
      if (i == 200) pulseReset();
    end

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
